// File: rtl/elastic_stage_reg_pkg.sv
// Shared types and widths for the elastic pipeline stage register.
// Holds the state encoding and the default field widths of the datapath.
package elastic_stage_reg_pkg;

   localparam int ADDRESS_LEN         = 32;
   localparam int REGISTER_LEN        = 32;
   localparam int REGFILE_ADDRESS_LEN = 4;

   // The encoding doubles as the occupancy count: EMPTY=0, FULL=1, SKID=2.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

endpackage

// File: rtl/elastic_stage_reg_slot.sv
// One {pc, ctrl, data} holding register with load enable and ctrl clear.
// A ctrl clear wins over a load so that a flushed slot can never carry live control.
module elastic_stage_reg_slot
   import elastic_stage_reg_pkg::*;
#(
   parameter int PC_W   = 32,
   parameter int CTRL_W = 3,
   parameter int DATA_W = 68
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clr_ctrl_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [PC_W-1:0]   pc_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic [PC_W-1:0]   pc_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= '0;
         ctrl_q <= '0;
         data_q <= '0;
      end else if (clr_ctrl_i) begin
         ctrl_q <= '0;
      end else if (load_i) begin
         pc_q   <= pc_i;
         ctrl_q <= ctrl_i;
         data_q <= data_i;
      end
   end

   assign pc_o   = pc_q;
   assign ctrl_o = ctrl_q;
   assign data_o = data_q;

endmodule

// File: rtl/elastic_stage_reg.sv
// Valid/ready pipeline stage register with flush and an optional 2-entry skid buffer.
// With SKID=1 in_ready depends only on state flops, cutting the ready chain between stages.
module elastic_stage_reg
   import elastic_stage_reg_pkg::*;
#(
   parameter int PC_W   = ADDRESS_LEN,
   parameter int CTRL_W = 3,
   parameter int DATA_W = 2*REGISTER_LEN + REGFILE_ADDRESS_LEN,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   state_e            state_q, state_d;
   logic              accept, emit;
   logic              main_ld, main_from_skid, skid_ld;
   logic [PC_W-1:0]   main_pc_d, skid_pc;
   logic [CTRL_W-1:0] main_ctrl_d, main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data_d, skid_data;

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;
   assign occupancy = state_q;

   // Ready is forced low while reset is held so nothing is taken during reset.
   generate
      if (SKID != 0) begin : g_rdy_reg
         assign in_ready = !rst && (state_q != ST_SKID);
      end else begin : g_rdy_pass
         assign in_ready = !rst && (!out_valid || out_ready);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) begin
               main_ld = 1'b1;
               state_d = ST_FULL;
            end
            ST_FULL: begin
               // Without a skid slot an accept in FULL always coincides with an emit.
               if (accept && !emit && (SKID != 0)) begin
                  skid_ld = 1'b1;
                  state_d = ST_SKID;
               end else if (accept) begin
                  main_ld = 1'b1;
               end else if (emit) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_SKID: if (emit) begin
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ST_FULL;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign main_pc_d   = main_from_skid ? skid_pc   : in_pc;
   assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_data_d = main_from_skid ? skid_data : in_data;

   elastic_stage_reg_slot #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk        (clk),
      .rst        (rst),
      .load_i     (main_ld),
      .clr_ctrl_i (flush),
      .pc_i       (main_pc_d),
      .ctrl_i     (main_ctrl_d),
      .data_i     (main_data_d),
      .pc_o       (out_pc),
      .ctrl_o     (main_ctrl),
      .data_o     (out_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         elastic_stage_reg_slot #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk        (clk),
            .rst        (rst),
            .load_i     (skid_ld),
            .clr_ctrl_i (flush),
            .pc_i       (in_pc),
            .ctrl_i     (in_ctrl),
            .data_i     (in_data),
            .pc_o       (skid_pc),
            .ctrl_o     (skid_ctrl),
            .data_o     (skid_data)
         );
      end else begin : g_noskid
         wire unused_skid_ld = skid_ld;
         assign skid_pc   = '0;
         assign skid_ctrl = '0;
         assign skid_data = '0;
      end
   endgenerate

   assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule
